// File: rtl/mux_bit_deserializer.sv
// mux_bit_deserializer
// Packs the serial output of the 2:1 select mux (Y_in, qualified by Y_valid)
// into WIDTH-bit words and presents them on a valid/ready port. Storage is a
// one-word output register plus one pending word. Bits arriving while both
// are occupied are dropped and flagged in a sticky overflow bit.
//
// Output handshake: word_out/word_valid form a valid/ready source. A word is
// consumed on a rising edge where word_valid=1 and word_ready=1. While
// word_valid=1 and word_ready=0, word_out is held stable. word_valid falls
// only on a consume edge that does not load a new word.
//
// dbg_state exposes the FSM state (0 = SHIFT, 1 = PEND) for observation.
module mux_bit_deserializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     Y_in,
  input  logic                     Y_valid,
  input  logic                     word_ready,
  input  logic                     ovf_clr,
  output logic [WIDTH-1:0]         word_out,
  output logic                     word_valid,
  output logic                     overflow,
  output logic [$clog2(WIDTH)-1:0] bit_count,
  output logic                     dbg_state
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic {
    ST_SHIFT = 1'b0,
    ST_PEND  = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [WIDTH-1:0] pend_q, pend_d;
  logic [WIDTH-1:0] word_out_q, word_out_d;
  logic             word_valid_q, word_valid_d;
  logic             overflow_q, overflow_d;
  logic [CW-1:0]    bit_count_q, bit_count_d;

  logic             slot_free;
  logic             consume;
  logic             completing;
  logic [WIDTH-1:0] shifted;

  // Handshake qualifiers and the shift register with the new bit inserted.
  // The completing bit is the one that lands when WIDTH-1 bits are already held.
  always_comb begin
    slot_free  = !word_valid_q || word_ready;
    consume    = word_valid_q && word_ready;
    completing = (bit_count_q == LAST_BIT);
    if (MSB_FIRST) begin
      shifted = {shift_q[WIDTH-2:0], Y_in};
    end else begin
      shifted = {Y_in, shift_q[WIDTH-1:1]};
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_SHIFT;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: park in PEND when a word completes with the output slot busy;
  // leave PEND as soon as the output word is consumed.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_SHIFT: begin
        if (Y_valid && completing && !slot_free) begin
          state_d = ST_PEND;
        end
      end
      ST_PEND: begin
        if (consume) begin
          state_d = ST_SHIFT;
        end
      end
      default: state_d = ST_SHIFT;
    endcase
  end

  // Datapath next values: accept/pack bits in SHIFT, drop them in PEND,
  // move completed words into the output or pending register.
  always_comb begin
    shift_d      = shift_q;
    pend_d       = pend_q;
    word_out_d   = word_out_q;
    word_valid_d = word_valid_q;
    bit_count_d  = bit_count_q;
    overflow_d   = overflow_q;
    if (ovf_clr) begin
      overflow_d = 1'b0;
    end
    case (state_q)
      ST_SHIFT: begin
        if (consume) begin
          word_valid_d = 1'b0;
        end
        if (Y_valid) begin
          if (completing) begin
            bit_count_d = '0;
            shift_d     = '0;
            if (slot_free) begin
              word_out_d   = shifted;
              word_valid_d = 1'b1;
            end else begin
              pend_d = shifted;
            end
          end else begin
            shift_d     = shifted;
            bit_count_d = bit_count_q + 1'b1;
          end
        end
      end
      ST_PEND: begin
        // A drop wins over a same-edge clear.
        if (Y_valid) begin
          overflow_d = 1'b1;
        end
        if (consume) begin
          word_out_d   = pend_q;
          word_valid_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Datapath registers; reset discards any partial word immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_q      <= '0;
      pend_q       <= '0;
      word_out_q   <= '0;
      word_valid_q <= 1'b0;
      bit_count_q  <= '0;
      overflow_q   <= 1'b0;
    end else begin
      shift_q      <= shift_d;
      pend_q       <= pend_d;
      word_out_q   <= word_out_d;
      word_valid_q <= word_valid_d;
      bit_count_q  <= bit_count_d;
      overflow_q   <= overflow_d;
    end
  end

  // Output drive.
  always_comb begin
    word_out   = word_out_q;
    word_valid = word_valid_q;
    overflow   = overflow_q;
    bit_count  = bit_count_q;
    dbg_state  = state_q;
  end

endmodule

// File: tb/tb_mux_bit_deserializer.sv
// Testbench for mux_bit_deserializer: two instances (MSB-first and LSB-first)
// share one input stream and are compared against a queue-based word model.
module tb_mux_bit_deserializer;

  localparam int W = 8;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst;
  logic Y_in, Y_valid, word_ready, ovf_clr;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  logic [W-1:0] wo_m, wo_l;
  logic         wv_m, wv_l, ovf_m, ovf_l, st_m, st_l;
  logic [2:0]   bc_m, bc_l;

  mux_bit_deserializer #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
    .clk(clk), .rst(rst), .Y_in(Y_in), .Y_valid(Y_valid),
    .word_ready(word_ready), .ovf_clr(ovf_clr),
    .word_out(wo_m), .word_valid(wv_m), .overflow(ovf_m),
    .bit_count(bc_m), .dbg_state(st_m)
  );

  mux_bit_deserializer #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .rst(rst), .Y_in(Y_in), .Y_valid(Y_valid),
    .word_ready(word_ready), .ovf_clr(ovf_clr),
    .word_out(wo_l), .word_valid(wv_l), .overflow(ovf_l),
    .bit_count(bc_l), .dbg_state(st_l)
  );

  // ---------------- reference model ----------------
  // acc_bits: accepted bits of the current partial word, in arrival order.
  // out_m/out_l: words waiting at the output (front = word_out, second = pending).
  logic         acc_bits[$];
  logic [W-1:0] out_m[$];
  logic [W-1:0] out_l[$];
  logic [W-1:0] last_m, last_l;
  logic         m_ovf;

  int tests_run = 0;
  int tests_failed = 0;

  task automatic model_reset();
    acc_bits.delete();
    out_m.delete();
    out_l.delete();
    last_m = '0;
    last_l = '0;
    m_ovf  = 1'b0;
  endtask

  task automatic model_edge(input logic yv, input logic yi, input logic rdy, input logic clr);
    int sz;
    bit drop;
    bit cons;
    logic [W-1:0] wm, wl;
    sz   = out_m.size();
    drop = 1'b0;
    cons = (sz > 0) && rdy;
    if (yv) begin
      if (sz == 2) begin
        drop = 1'b1;
      end else begin
        acc_bits.push_back(yi);
        if (acc_bits.size() == W) begin
          wm = '0;
          wl = '0;
          for (int i = 0; i < W; i++) begin
            wm[W-1-i] = acc_bits[i];
            wl[i]     = acc_bits[i];
          end
          out_m.push_back(wm);
          out_l.push_back(wl);
          acc_bits.delete();
        end
      end
    end
    if (drop) m_ovf = 1'b1;
    else if (clr) m_ovf = 1'b0;
    if (cons) begin
      last_m = out_m.pop_front();
      last_l = out_l.pop_front();
    end
  endtask

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    int sz;
    logic [W-1:0] em, el;
    sz = out_m.size();
    em = (sz > 0) ? out_m[0] : last_m;
    el = (sz > 0) ? out_l[0] : last_l;
    check("word_valid_m", 32'(wv_m), 32'(sz > 0));
    check("word_valid_l", 32'(wv_l), 32'(sz > 0));
    check("word_out_m", 32'(wo_m), 32'(em));
    check("word_out_l", 32'(wo_l), 32'(el));
    check("overflow_m", 32'(ovf_m), 32'(m_ovf));
    check("overflow_l", 32'(ovf_l), 32'(m_ovf));
    check("bit_count_m", 32'(bc_m), 32'(acc_bits.size()));
    check("bit_count_l", 32'(bc_l), 32'(acc_bits.size()));
    check("state_m", 32'(st_m), 32'(sz == 2));
    check("state_l", 32'(st_l), 32'(sz == 2));
  endtask

  // ---------------- driver tasks ----------------
  // Called at a falling edge; drives inputs, lets one rising edge pass,
  // updates the model, then checks at the following falling edge.
  task automatic cycle(input logic yv, input logic yi, input logic rdy, input logic clr);
    Y_valid    = yv;
    Y_in       = yv ? yi : 1'bx;
    word_ready = rdy;
    ovf_clr    = clr;
    @(posedge clk);
    model_edge(yv, yi, rdy, clr);
    @(negedge clk);
    check_all();
  endtask

  // Sends b[7] first, one bit per cycle.
  task automatic send_byte(input logic [7:0] b, input logic rdy);
    for (int i = W - 1; i >= 0; i--) begin
      cycle(1'b1, b[i], rdy, 1'b0);
    end
  endtask

  // ---------------- stimulus ----------------
  logic [7:0] pat;
  int         pulse_cyc[$];

  initial begin
    model_reset();
    rst = 1'b1;
    Y_valid = 1'b0; Y_in = 1'b0; word_ready = 1'b0; ovf_clr = 1'b0;
    #1;
    check_all();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_all();

    // Basic packing, both bit orders.
    pat = 8'hB2;
    send_byte(pat, 1'b1);
    check("basic_msb_word", 32'(wo_m), 32'h0B2);
    check("basic_lsb_word", 32'(wo_l), 32'h04D);
    check("basic_valid", 32'(wv_m), 32'd1);
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    check("basic_valid_pulse", 32'(wv_m), 32'd0);

    // Same word with idle gaps (Y_in is X during gaps).
    for (int i = W - 1; i >= 0; i--) begin
      cycle(1'b1, pat[i], 1'b1, 1'b0);
      if (i != 0) begin
        cycle(1'b0, 1'b0, 1'b1, 1'b0);
        cycle(1'b0, 1'b1, 1'b1, 1'b0);
        check("gap_bit_count", 32'(bc_m), 32'(W - i));
      end
    end
    check("gap_msb_word", 32'(wo_m), 32'h0B2);
    check("gap_lsb_word", 32'(wo_l), 32'h04D);
    cycle(1'b0, 1'b0, 1'b1, 1'b0);

    // Backpressure: A5 held, 3C pending, further bits dropped.
    send_byte(8'hA5, 1'b0);
    send_byte(8'h3C, 1'b0);
    check("bp_held_word", 32'(wo_m), 32'h0A5);
    check("bp_state_pend", 32'(st_m), 32'd1);
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
    check("bp_overflow", 32'(ovf_m), 32'd1);
    check("bp_bit_count", 32'(bc_m), 32'd0);
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    check("bp_next_word", 32'(wo_m), 32'h03C);
    check("bp_valid_stays", 32'(wv_m), 32'd1);
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    check("ovf_cleared", 32'(ovf_m), 32'd0);

    // Drop and clear on the same edge: set wins.
    send_byte(8'($urandom), 1'b0);
    cycle(1'b1, 1'b1, 1'b0, 1'b1);
    check("drop_vs_clr", 32'(ovf_m), 32'd1);
    cycle(1'b0, 1'b0, 1'b1, 1'b1);
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 1'b0);

    // Back-to-back streaming: two pulses exactly 8 cycles apart.
    pulse_cyc.delete();
    pat = 8'hF0;
    for (int k = 0; k < 2 * W + 2; k++) begin
      if (k < 2 * W) cycle(1'b1, (k < W) ? pat[W-1-k] : ~pat[W-1-(k-W)], 1'b1, 1'b0);
      else cycle(1'b0, 1'b0, 1'b1, 1'b0);
      if (wv_m) pulse_cyc.push_back(k);
    end
    check("stream_pulses", 32'(pulse_cyc.size()), 32'd2);
    if (pulse_cyc.size() == 2) check("stream_spacing", 32'(pulse_cyc[1] - pulse_cyc[0]), 32'd8);
    check("stream_no_ovf", 32'(ovf_m), 32'd0);

    // Asynchronous reset in the middle of a partial word.
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b1, 1'b1, 1'b0);
    send_byte(8'h00, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    check("async_bit_count", 32'(bc_m), 32'd0);
    check("async_valid", 32'(wv_m), 32'd0);
    check("async_state", 32'(st_m), 32'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    check_all();
    send_byte(8'h81, 1'b1);
    check("post_reset_word", 32'(wo_m), 32'h081);
    check("post_reset_word_l", 32'(wo_l), 32'h081);
    cycle(1'b0, 1'b0, 1'b1, 1'b0);

    // Randomized traffic with varying backpressure and occasional clears.
    for (int k = 0; k < 600; k++) begin
      cycle(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
            1'((k / 50) % 2 == 0 ? $urandom_range(0, 3) != 0 : $urandom_range(0, 4) == 0),
            1'($urandom_range(0, 15) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
